// File: rtl/scalar_mul_record_writer.sv
// Writes the four-word scalar-multiplication parameter record to outer RAM,
// optionally reads it back, and launches the sequencer on success.
module scalar_mul_record_writer #(
  parameter int Data   = 255,
  parameter int Addr   = 5,
  parameter bit VERIFY = 1'b1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            load,
  input  logic [Addr:0]   base_addr,
  input  logic [Data:0]   poly_word,
  input  logic [9:0]      poly_len,
  input  logic [575:0]    key,
  output logic            ram_req,
  input  logic            ram_gnt,
  output logic            ram_w,
  output logic [Addr:0]   ram_adbus,
  output logic [Data:0]   ram_data_in,
  input  logic [Data:0]   ram_data_out,
  output logic            busy,
  output logic            done,
  output logic [1:0]      err,
  output logic            start_operation
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_ARB  = 3'd1;
  localparam logic [2:0] S_WR   = 3'd2;
  localparam logic [2:0] S_VER  = 3'd3;
  localparam logic [2:0] S_DONE = 3'd4;

  localparam logic [Addr:0] MaxBase = (Addr+1)'(60);
  localparam logic [9:0]    MaxLen  = 10'd767;

  logic [2:0]    r_state;
  logic [1:0]    r_idx;
  logic [1:0]    r_cidx;
  logic          r_cvld;
  logic          r_rd_all;
  logic [Addr:0] r_base;
  logic [Data:0] r_w0;
  logic [575:0]  r_key;
  logic [1:0]    r_err;

  logic [Data:0] w_w0_in;
  logic [Addr:0] w_addr;
  logic          w_issue;

  function automatic logic [Data:0] word_at(input logic [1:0] i);
    logic [Data:0] w;
    case (i)
      2'd0:    w = r_w0;
      2'd1:    w = {{(Data-63){1'b0}}, r_key[575:512]};
      2'd2:    w = r_key[511:256];
      default: w = r_key[255:0];
    endcase
    return w;
  endfunction

  always_comb begin
    w_w0_in = poly_word;
    w_w0_in[41:32] = poly_len;
  end

  assign w_addr  = r_base + {{(Addr-1){1'b0}}, r_idx};
  assign w_issue = (r_state == S_VER) && ram_gnt && !r_rd_all;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_idx    <= 2'd0;
      r_cidx   <= 2'd0;
      r_cvld   <= 1'b0;
      r_rd_all <= 1'b0;
      r_base   <= '0;
      r_w0     <= '0;
      r_key    <= '0;
      r_err    <= 2'b00;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (load) begin
            r_base   <= base_addr;
            r_w0     <= w_w0_in;
            r_key    <= key;
            r_idx    <= 2'd0;
            r_cvld   <= 1'b0;
            r_rd_all <= 1'b0;
            if (poly_len > MaxLen) begin
              r_err   <= 2'b01;
              r_state <= S_DONE;
            end else if (base_addr > MaxBase) begin
              r_err   <= 2'b10;
              r_state <= S_DONE;
            end else begin
              r_err   <= 2'b00;
              r_state <= S_ARB;
            end
          end
        end
        S_ARB: begin
          if (ram_gnt) r_state <= S_WR;
        end
        S_WR: begin
          if (ram_gnt) begin
            r_idx <= r_idx + 2'd1;
            if (r_idx == 2'd3)
              r_state <= VERIFY ? S_VER : S_DONE;
          end
        end
        S_VER: begin
          // issue and compare overlap; a stall only drops the issue slot
          r_cvld <= w_issue;
          r_cidx <= r_idx;
          if (w_issue) begin
            r_idx <= r_idx + 2'd1;
            if (r_idx == 2'd3) r_rd_all <= 1'b1;
          end
          if (r_cvld) begin
            if (ram_data_out != word_at(r_cidx)) begin
              r_err   <= 2'b11;
              r_state <= S_DONE;
            end else if (r_cidx == 2'd3) begin
              r_state <= S_DONE;
            end
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  always_comb begin
    ram_req = (r_state == S_ARB) ||
              (r_state == S_WR)  ||
              (r_state == S_VER);
    ram_w = (r_state == S_WR) && ram_gnt;
    ram_adbus = '0;
    ram_data_in = '0;
    if (ram_w || w_issue) ram_adbus = w_addr;
    if (ram_w) ram_data_in = word_at(r_idx);
    busy = (r_state != S_IDLE);
    done = (r_state == S_DONE);
    start_operation = done && (r_err == 2'b00);
  end

  assign err = r_err;

endmodule
